sp_ram_ctrl: RTL and testbench

//  Initiator-side controller for a single-port synchronous RAM with a 1-cycle registered read.

---
 rtl/sp_ram_ctrl_pkg.sv | 21 ++
 rtl/sp_ram_ctrl_fifo.sv | 61 ++++++
 rtl/sp_ram_ctrl.sv | 89 ++++++++
 tb/tb_sp_ram_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_ctrl_pkg.sv
// Shared defaults, request opcode encoding and sizing helper for the sp_ram controller.
package sp_ram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_RSP_DEPTH  = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } req_op_e;

  // Number of bits needed to index 'value' entries (ceiling log2).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((32'd1 << res) < 32'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/sp_ram_ctrl_fifo.sv
// One-clock FIFO for the read-response queue; head entry is presented combinationally.
module sync_fifo
  import sp_ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_RSP_DEPTH,
  localparam int PTR_W     = clog2(DEPTH),
  localparam int CNT_W     = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  push_en_s;
  logic                  pop_en_s;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    empty     = (count_r == '0);
    full      = (count_r == CNT_W'(DEPTH));
    push_en_s = push & ~full;
    pop_en_s  = pop & ~empty;
    count     = count_r;
    pop_data  = mem_r[rd_ptr_r];
  end

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_en_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM initiator: request stream to RAM strobes, in-order read responses
// through a credit-limited response FIFO.
module sp_ram_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_rd_ena,
  output logic                  ram_wr_ena,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  busy
);

  localparam int CNT_W = clog2(RSP_DEPTH) + 1;

  logic             rd_pend_r;
  logic [CNT_W-1:0] fifo_count_s;
  logic [CNT_W:0]   credit_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic             acc_s;
  logic             push_s;
  logic             pop_s;
  req_op_e          op_s;

  // Credit check, accept qualification and RAM strobe generation.
  always_comb begin
    credit_s    = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, rd_pend_r};
    req_ready   = (credit_s < (CNT_W + 1)'(RSP_DEPTH));
    op_s        = req_op_e'(req_write);
    // Strobes are held low while reset is asserted even though req_ready is high.
    acc_s       = req_valid & req_ready & rst_n;
    ram_wr_ena  = 1'b0;
    ram_rd_ena  = 1'b0;
    case (op_s)
      OP_WRITE: ram_wr_ena = acc_s;
      OP_READ:  ram_rd_ena = acc_s;
      default: begin
        ram_wr_ena = 1'b0;
        ram_rd_ena = 1'b0;
      end
    endcase
    ram_address = req_addr;
    ram_wr_data = req_wdata;
    push_s      = rd_pend_r & ~fifo_full_s;
    rsp_valid   = ~fifo_empty_s;
    pop_s       = rsp_ready & rsp_valid;
    busy        = rd_pend_r | ~fifo_empty_s;
  end

  // One-cycle read-in-flight flag: RAM data lands the cycle after a read accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r <= 1'b0;
    end else begin
      rd_pend_r <= ram_rd_ena;
    end
  end

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .push_data(ram_rd_data),
    .pop      (pop_s),
    .pop_data (rsp_rdata),
    .count    (fifo_count_s),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s)
  );

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Self-checking bench for sp_ram_ctrl with a behavioural 1-cycle RAM and a transaction-level
// reference model (outstanding-read queue, shadow memory, 2-cycle response latency).
module tb_sp_ram_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          ram_rd_ena;
  logic          ram_wr_ena;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data = '0;
  logic          busy;

  sp_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_rd_ena(ram_rd_ena), .ram_wr_ena(ram_wr_ena), .ram_address(ram_address),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: 1-cycle registered read
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wr_ena) ram_mem[ram_address] <= ram_wr_data;
    if (ram_rd_ena) ram_rd_data <= ram_mem[ram_address];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          model_q[$];
  logic [DW-1:0] popped_q[$];
  int            pop_cyc_q[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            ready_low = 0;
  logic [78:0]   obs_v, exp_v;

  // One clock of stimulus; samples DUT outputs at the falling edge and advances the model.
  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr);
    logic e_ready, e_valid, acc;
    logic [DW-1:0] e_data;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    e_ready = (model_q.size() < DEPTH);
    e_valid = (model_q.size() != 0) && (model_q[0].cyc + 2 <= cyc);
    e_data  = e_valid ? model_q[0].data : '0;
    acc     = v & e_ready;
    exp_v = {e_ready, e_valid, (model_q.size() != 0), acc & w, acc & ~w, a, d, e_data};
    obs_v = {req_ready, rsp_valid, busy, ram_wr_ena, ram_rd_ena, ram_address, ram_wr_data,
             (e_valid ? rsp_rdata : {DW{1'b0}})};
    if (!req_ready) ready_low++;
    @(posedge clk);
    if (e_valid && rr) begin
      popped_q.push_back(model_q[0].data);
      pop_cyc_q.push_back(cyc);
      void'(model_q.pop_front());
    end
    if (acc && w) shadow[a] = d;
    if (acc && !w) model_q.push_back('{shadow[a], cyc});
    if (acc) acc_cnt++;
    cyc++;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_write = i[0];
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, busy, ram_wr_ena, ram_rd_ena, rsp_rdata} !== {5'b10000, 32'h0}) begin
        n_fail++;
        $display("FAIL reset c%0d: got %b_%h expected 10000_00000000", i,
                 {req_ready, rsp_valid, busy, ram_wr_ena, ram_rd_ena}, rsp_rdata);
      end
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    model_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_drain(input string name);
    for (int i = 0; i < 12 && model_q.size() != 0; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL %s drain: got %h expected %h", name, obs_v, exp_v); end
    end
    n_checks++;
    if (model_q.size() != 0) begin
      n_fail++; $display("FAIL %s drain_timeout: got %0d pending expected 0", name, model_q.size());
    end
  endtask

  task automatic test_write_read;
    popped_q.delete();
    drive(1'b1, 1'b1, 10'h3A5, 32'hDEADBEEF, 1'b1);
    n_checks++;
    if (obs_v !== exp_v) begin n_fail++; $display("FAIL wr_rd write: got %h expected %h", obs_v, exp_v); end
    drive(1'b1, 1'b0, 10'h3A5, 32'h0, 1'b1);
    n_checks++;
    if (obs_v !== exp_v) begin n_fail++; $display("FAIL wr_rd read: got %h expected %h", obs_v, exp_v); end
    test_drain("wr_rd");
    n_checks++;
    if (popped_q.size() != 1 || popped_q[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_rd data: got %0d rsp first %h expected 1 rsp deadbeef",
                         popped_q.size(), (popped_q.size() != 0) ? popped_q[0] : 32'h0);
    end
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, AW'(i), DW'(i * 3), 1'b1);
    popped_q.delete(); pop_cyc_q.delete(); ready_low = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, AW'(i), '0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL stream r%0d: got %h expected %h", i, obs_v, exp_v); end
    end
    n_checks++;
    if (ready_low != 0) begin n_fail++; $display("FAIL stream ready_drop: got %0d expected 0", ready_low); end
    test_drain("stream");
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (popped_q.size() != 16 || popped_q[i] !== DW'(i * 3) || pop_cyc_q[i] != pop_cyc_q[0] + i) begin
        n_fail++; $display("FAIL stream rsp%0d: got %0d rsps expected 16 of addr*3 consecutive", i, popped_q.size());
      end
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] vals [6];
    int acc0;
    for (int i = 0; i < 6; i++) begin
      vals[i] = DW'($urandom);
      drive(1'b1, 1'b1, AW'(100 + i), vals[i], 1'b1);
    end
    popped_q.delete();
    acc0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, AW'(100 + (acc_cnt - acc0)), '0, 1'b0);
      n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL bp stall%0d: got %h expected %h", i, obs_v, exp_v); end
    end
    n_checks++;
    if (acc_cnt - acc0 != DEPTH || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp accepted: got %0d ready %b expected %0d ready 0", acc_cnt - acc0, req_ready, DEPTH);
    end
    test_drain("bp");
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (popped_q.size() != DEPTH || popped_q[i] !== vals[i]) begin
        n_fail++; $display("FAIL bp order%0d: got %h expected %h", i,
                           (i < popped_q.size()) ? popped_q[i] : 32'h0, vals[i]);
      end
    end
  endtask

  task automatic test_mixed;
    popped_q.delete();
    drive(1'b1, 1'b1, 10'd5, 32'h11, 1'b1);
    drive(1'b1, 1'b0, 10'd5, 32'h0, 1'b1);
    n_checks++;
    if (obs_v !== exp_v) begin n_fail++; $display("FAIL mixed r1: got %h expected %h", obs_v, exp_v); end
    drive(1'b1, 1'b1, 10'd5, 32'h22, 1'b1);
    n_checks++;
    if (obs_v !== exp_v) begin n_fail++; $display("FAIL mixed w2: got %h expected %h", obs_v, exp_v); end
    drive(1'b1, 1'b0, 10'd5, 32'h0, 1'b1);
    test_drain("mixed");
    n_checks++;
    if (popped_q.size() != 2 || popped_q[0] !== 32'h11 || popped_q[1] !== 32'h22) begin
      n_fail++; $display("FAIL mixed data: got %0d rsps expected 11,22", popped_q.size());
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, AW'(200 + i), DW'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, AW'(200 + i), '0, 1'b0);
    req_valid = 1'b0;
    rst_n = 1'b0;
    model_q.delete();
    #2;
    n_checks++;
    if ({rsp_valid, busy, rsp_rdata} !== {2'b00, 32'h0}) begin
      n_fail++; $display("FAIL midrst async: got v%b b%b %h expected v0 b0 0", rsp_valid, busy, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    popped_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL midrst idle%0d: got %h expected %h", i, obs_v, exp_v); end
    end
    drive(1'b1, 1'b0, AW'(203), '0, 1'b1);
    test_drain("midrst");
    n_checks++;
    if (popped_q.size() != 1 || popped_q[0] !== shadow[203]) begin
      n_fail++; $display("FAIL midrst read: got %0d rsps expected 1 of %h", popped_q.size(), shadow[203]);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
            DW'($urandom), $urandom_range(0, 3) != 0);
      n_checks++;
      if (obs_v !== exp_v) begin n_fail++; $display("FAIL random c%0d: got %h expected %h", i, obs_v, exp_v); end
    end
    test_drain("random");
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = '0;
      shadow[i]  = '0;
    end
    test_reset();
    test_write_read();
    test_streaming();
    test_backpressure();
    test_mixed();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
